// File: rtl/yuv_seq_ctrl_if.sv
// Handshake and control bundle between the YUV sequencing controller and its
// pixel source, pixel sink and datapath.
interface yuv_seq_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic             frame_last;
   logic [CNT_W-1:0] pix_cnt;
   logic             busy;
   logic [15:0]      control;

   modport master (
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_valid,
      output frame_last,
      output pix_cnt,
      output busy,
      output control
   );

   modport slave (
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  frame_last,
      input  pix_cnt,
      input  busy,
      input  control
   );
endinterface

// File: rtl/yuv_seq_ctrl.sv
// Sequences the RGB->YUV datapath through MUL/ADD/OUT for each of the Y, U and V
// channels, then presents the finished pixel and tracks its position in the frame.
module yuv_seq_ctrl #(
   parameter logic [2:0] OFFSET_MASK  = 3'b110,
   parameter int         FRAME_PIXELS = 64,
   parameter int         CNT_W        = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   yuv_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_ADD,
      S_OUT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

   state_t           state_q, state_d;
   logic [1:0]       ch_q, ch_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;

   logic             in_ready;
   logic             out_valid;
   logic             frame_last;
   logic             busy;
   logic [15:0]      control;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ch_q      <= 2'd0;
         pix_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         pix_cnt_q <= pix_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      pix_cnt_d  = pix_cnt_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      frame_last = 1'b0;
      busy       = 1'b1;
      control    = 16'h0000;

      case (state_q)
         S_IDLE: begin
            busy     = 1'b0;
            in_ready = 1'b1;
            if (bus.in_valid) begin
               control[15:13] = 3'b111;
               ch_d           = 2'd0;
               state_d        = S_MUL;
            end
         end

         S_MUL: begin
            control[12]  = 1'b1;
            control[11]  = 1'b1;
            control[8]   = 1'b1;
            control[4:3] = ch_q;
            state_d      = S_ADD;
         end

         S_ADD: begin
            control[9]   = 1'b1;
            control[4:3] = ch_q;
            if (OFFSET_MASK[ch_q]) begin
               control[10] = 1'b1;
               control[2]  = 1'b1;
            end
            state_d = S_OUT;
         end

         S_OUT: begin
            control[7:5] = 3'b100 >> ch_q;
            control[0]   = OFFSET_MASK[ch_q];
            // ROM is registered: issue the next channel's index now so it is ready at MUL.
            if (ch_q == 2'd2) begin
               control[4:3] = 2'd0;
               state_d      = S_DONE;
            end else begin
               control[4:3] = ch_q + 2'd1;
               ch_d         = ch_q + 2'd1;
               state_d      = S_MUL;
            end
         end

         S_DONE: begin
            out_valid  = 1'b1;
            frame_last = (pix_cnt_q == LAST_PIX);
            if (bus.out_ready) begin
               pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + 1'b1;
               state_d   = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.frame_last = frame_last;
   assign bus.pix_cnt    = pix_cnt_q;
   assign bus.busy       = busy;
   assign bus.control    = control;

endmodule

// File: tb/tb_yuv_seq_ctrl.sv
// Bench for yuv_seq_ctrl: three configurations driven with randomized pacing and
// checked cycle by cycle against a channel/phase level reference model.
module tb_yuv_seq_ctrl;

   localparam int N = 3;
   localparam int FP_T [N] = '{64, 4, 1};
   localparam logic [2:0] MASK_T [N] = '{3'b110, 3'b000, 3'b110};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]       rst_n, in_valid, out_ready;
   logic [N-1:0]       in_ready, out_valid, frame_last, busy;
   logic [N-1:0][15:0] control, pix_cnt;

   int tests = 0;
   int fails = 0;
   int exp_cnt [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_dut
         yuv_seq_ctrl_if #(.CNT_W(16)) bus ();
         assign bus.in_valid   = in_valid[gi];
         assign bus.out_ready  = out_ready[gi];
         assign in_ready[gi]   = bus.in_ready;
         assign out_valid[gi]  = bus.out_valid;
         assign frame_last[gi] = bus.frame_last;
         assign busy[gi]       = bus.busy;
         assign control[gi]    = bus.control;
         assign pix_cnt[gi]    = bus.pix_cnt;

         yuv_seq_ctrl #(
            .OFFSET_MASK (MASK_T[gi]),
            .FRAME_PIXELS(FP_T[gi]),
            .CNT_W       (16)
         ) u_dut (
            .clk  (clk),
            .rst_n(rst_n[gi]),
            .bus  (bus.master)
         );
      end
   endgenerate

   // Expected control word for step p (0..8) of a pixel: channel p/3, sub-step MUL/ADD/OUT.
   function automatic logic [15:0] exp_ctrl(input int p, input logic [2:0] mask);
      int ch;
      int nxt;
      logic [15:0] c;
      ch = p / 3;
      c  = 16'h0000;
      case (p % 3)
         0: c = 16'h1900 | 16'(ch * 8);
         1: begin
            c = 16'h0200 | 16'(ch * 8);
            if (mask[ch]) c = c | 16'h0404;
         end
         default: begin
            nxt = (ch < 2) ? ch + 1 : 0;
            c = (16'h0080 >> ch) | 16'(nxt * 8);
            if (mask[ch]) c = c | 16'h0001;
         end
      endcase
      return c;
   endfunction

   // Runs one pixel on instance k starting from IDLE (just after a falling edge).
   // abort_p >= 0 pulses reset at that step and discards the pixel.
   task automatic do_pixel(input int k, input int idle_cyc, input int stall, input int abort_p);
      logic [3:0] st;
      logic [3:0] st_exp;
      logic       last;
      for (int i = 0; i < idle_cyc; i++) begin
         @(negedge clk);
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'($urandom);
         #1;
         tests++;
         st = {busy[k], in_ready[k], out_valid[k], frame_last[k]};
         if (st !== 4'b0100 || control[k] !== 16'h0000) begin
            fails++;
            $display("FAIL idle_wait inst%0d: status=%b ctrl=%h, required status=0100 ctrl=0000", k, st, control[k]);
         end
      end

      in_valid[k] = 1'b1;
      #1;
      tests++;
      if (control[k] !== 16'hE000 || in_ready[k] !== 1'b1) begin
         fails++;
         $display("FAIL accept inst%0d: ctrl=%h in_ready=%b, required ctrl=e000 in_ready=1", k, control[k], in_ready[k]);
      end

      for (int p = 0; p < 9; p++) begin
         @(negedge clk);
         in_valid[k]  = 1'($urandom);
         out_ready[k] = 1'($urandom);
         if (p == abort_p) begin
            rst_n[k]    = 1'b0;
            in_valid[k] = 1'b0;
            #1;
            tests++;
            st = {busy[k], in_ready[k], out_valid[k], frame_last[k]};
            if (st !== 4'b0100 || control[k] !== 16'h0000 || pix_cnt[k] !== 16'h0000) begin
               fails++;
               $display("FAIL reset_mid inst%0d: status=%b ctrl=%h cnt=%0d, required status=0100 ctrl=0000 cnt=0",
                        k, st, control[k], pix_cnt[k]);
            end
            exp_cnt[k] = 0;
            @(negedge clk);
            rst_n[k] = 1'b1;
            #1;
            return;
         end
         #1;
         tests++;
         st = {busy[k], in_ready[k], out_valid[k], frame_last[k]};
         if (control[k] !== exp_ctrl(p, MASK_T[k]) || st !== 4'b1000 || pix_cnt[k] !== 16'(exp_cnt[k])) begin
            fails++;
            $display("FAIL step%0d inst%0d: ctrl=%h status=%b cnt=%0d, required ctrl=%h status=1000 cnt=%0d",
                     p, k, control[k], st, pix_cnt[k], exp_ctrl(p, MASK_T[k]), exp_cnt[k]);
         end
      end

      last   = (exp_cnt[k] == FP_T[k] - 1);
      st_exp = {3'b101, last};
      for (int s = 0; s <= stall; s++) begin
         @(negedge clk);
         out_ready[k] = (s == stall);
         in_valid[k]  = (s == stall) ? 1'b0 : 1'($urandom);
         #1;
         tests++;
         st = {busy[k], in_ready[k], out_valid[k], frame_last[k]};
         if (st !== st_exp || control[k] !== 16'h0000 || pix_cnt[k] !== 16'(exp_cnt[k])) begin
            fails++;
            $display("FAIL done inst%0d wait%0d: status=%b ctrl=%h cnt=%0d, required status=%b ctrl=0000 cnt=%0d",
                     k, s, st, control[k], pix_cnt[k], st_exp, exp_cnt[k]);
         end
      end

      @(negedge clk);
      out_ready[k] = 1'b0;
      exp_cnt[k]   = (exp_cnt[k] + 1) % FP_T[k];
      #1;
      tests++;
      st = {busy[k], in_ready[k], out_valid[k], frame_last[k]};
      if (st !== 4'b0100 || control[k] !== 16'h0000 || pix_cnt[k] !== 16'(exp_cnt[k])) begin
         fails++;
         $display("FAIL back_to_idle inst%0d: status=%b ctrl=%h cnt=%0d, required status=0100 ctrl=0000 cnt=%0d",
                  k, st, control[k], pix_cnt[k], exp_cnt[k]);
      end
   endtask

   task automatic test_reset();
      logic [3:0] st;
      @(negedge clk);
      @(negedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         tests++;
         st = {busy[k], in_ready[k], out_valid[k], frame_last[k]};
         if (st !== 4'b0100 || control[k] !== 16'h0000 || pix_cnt[k] !== 16'h0000) begin
            fails++;
            $display("FAIL reset inst%0d: status=%b ctrl=%h cnt=%0d, required status=0100 ctrl=0000 cnt=0",
                     k, st, control[k], pix_cnt[k]);
         end
      end
      @(negedge clk);
      rst_n = '1;
      #1;
   endtask

   task automatic test_control_sequence();
      do_pixel(0, 0, 0, -1);
   endtask

   task automatic test_out_stall();
      do_pixel(0, 1, 5, -1);
   endtask

   task automatic test_random_pacing();
      for (int i = 0; i < 6; i++)
         do_pixel(0, $urandom_range(0, 3), $urandom_range(0, 4), -1);
   endtask

   task automatic test_reset_mid_pixel();
      do_pixel(0, 0, 0, 4);
      do_pixel(0, 0, 1, -1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 9; i++)
         do_pixel(1, 0, $urandom_range(0, 2), -1);
   endtask

   task automatic test_single_pixel_frame();
      for (int i = 0; i < 4; i++)
         do_pixel(2, $urandom_range(0, 2), $urandom_range(0, 3), -1);
   endtask

   task automatic test_random_mix();
      for (int i = 0; i < 10; i++)
         do_pixel(int'($urandom_range(0, N - 1)), $urandom_range(0, 2), $urandom_range(0, 3), -1);
   endtask

   initial begin
      rst_n     = '0;
      in_valid  = '0;
      out_ready = '0;
      for (int k = 0; k < N; k++) exp_cnt[k] = 0;

      test_reset();
      test_control_sequence();
      test_out_stall();
      test_random_pacing();
      test_reset_mid_pixel();
      test_back_to_back();
      test_single_pixel_frame();
      test_random_mix();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
